// File: rtl/segway_uart_pkg.sv
// Shared types and timing constants for the Segway UART command path.
package segway_uart_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_LO = 1'b1
   } asm_state_t;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned BAUD            = 19200;
   localparam int unsigned BAUD_DIV        = 2604;
   localparam int unsigned DEF_CMD_TIMEOUT = 104160;

endpackage : segway_uart_pkg

// File: rtl/uart_cmd_assembler.sv
// Pairs received UART bytes (high byte first) into 16-bit commands, with an
// inter-byte timeout that drops a dangling high byte to keep frames aligned.
module uart_cmd_assembler
   import segway_uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_CMD_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        timeout_err
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   asm_state_t    state_q, state_d;
   logic [7:0]    hi_byte_q, hi_byte_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   cmd_q, cmd_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          timeout_err_q, timeout_err_d;

   // Both states take a byte the moment it shows up; there is no backpressure.
   assign clr_rx_rdy  = rx_rdy;
   assign cmd         = cmd_q;
   assign cmd_rdy     = cmd_rdy_q;
   assign timeout_err = timeout_err_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      hi_byte_d     = hi_byte_q;
      timer_d       = timer_q;
      cmd_d         = cmd_q;
      cmd_rdy_d     = cmd_rdy_q & ~clr_cmd_rdy;
      timeout_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (rx_rdy) begin
               hi_byte_d = rx_data;
               cmd_rdy_d = 1'b0;
               state_d   = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (rx_rdy) begin
               // Completion overrides a same-cycle clr_cmd_rdy.
               cmd_d     = {hi_byte_q, rx_data};
               cmd_rdy_d = 1'b1;
               timer_d   = '0;
               state_d   = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               timeout_err_d = 1'b1;
               timer_d       = '0;
               state_d       = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         hi_byte_q     <= 8'h00;
         timer_q       <= '0;
         cmd_q         <= 16'h0000;
         cmd_rdy_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hi_byte_q     <= hi_byte_d;
         timer_q       <= timer_d;
         cmd_q         <= cmd_d;
         cmd_rdy_q     <= cmd_rdy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule : uart_cmd_assembler

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Sits directly downstream of the UART byte receiver in the Segway command path. It consumes received bytes over the receiver's rdy/clr_rdy handshake and assembles two consecutive bytes, high byte first, into one 16-bit command. It presents that command to the command processor with its own ready/clear handshake. An inter-byte timeout discards a dangling high byte so a dropped byte cannot misalign later frames.

Parameters:
TIMEOUT_CYCLES, 104160, clk cycles allowed between high-byte acceptance and low-byte arrival (~4 byte times at 19200 baud, 50 MHz); counter width = $clog2(TIMEOUT_CYCLES).

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  receiver byte-valid (level, held until cleared)
rx_data  input  8  received byte, valid while rx_rdy=1
clr_rx_rdy  output  1  combinational consume pulse to receiver's clr_rdy
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  command valid (registered level)
clr_cmd_rdy  input  1  downstream acknowledge, clears cmd_rdy
timeout_err  output  1  one-cycle registered pulse when a partial frame is discarded

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE, cmd=16'h0000, cmd_rdy=0, timeout_err=0, hi_byte=8'h00, timer=0.
- clr_rx_rdy = rx_rdy (both states always accept a byte). The receiver drops rdy on the next edge, so each byte is consumed exactly once. clr_rx_rdy is never asserted while rx_rdy=0.
- States (enum, 1 bit): IDLE (waiting for high byte), WAIT_LO (holding high byte).
- IDLE, rx_rdy=1:
  - hi_byte <= rx_data; timer <= 0; cmd_rdy <= 0 (new frame start knocks down a stale rdy); next state WAIT_LO.
  - cmd keeps its previous value.
- IDLE, rx_rdy=0: hold; timer holds 0.
- WAIT_LO, rx_rdy=1:
  - cmd <= {hi_byte, rx_data}; cmd_rdy <= 1; next state IDLE.
  - cmd and cmd_rdy update on the same edge; latency = 1 clk after the low byte's rx_rdy.
- WAIT_LO, rx_rdy=0, timer != TIMEOUT_CYCLES-1: timer <= timer+1.
- WAIT_LO, rx_rdy=0, timer == TIMEOUT_CYCLES-1:
  - next state IDLE; timeout_err <= 1 for exactly one cycle; hi_byte is discarded.
  - cmd and cmd_rdy are untouched.
- Simultaneous events:
  - rx_rdy with timer at terminal count: the byte wins; the frame completes and no timeout_err fires.
  - clr_cmd_rdy with frame completion in the same cycle: set wins, cmd_rdy=1.
  - clr_cmd_rdy with a high-byte start: cmd_rdy=0.
- cmd_rdy clears on clr_cmd_rdy or on the next high-byte acceptance; otherwise it holds. Holding cmd_rdy does not stall byte acceptance; there is no backpressure to the UART.
- cmd is stable from completion until the next completion.
- timer counts only in WAIT_LO (power); it is zero whenever state=IDLE.
- Reset mid-frame (WAIT_LO): immediate return to IDLE; partial byte lost; no timeout_err.

Decomposition:
- Shared package segway_uart_pkg holds:
  - typedef enum logic {IDLE, WAIT_LO} asm_state_t
  - constants CLK_HZ=50_000_000, BAUD=19200, BAUD_DIV=2604, DEF_CMD_TIMEOUT=104160
- No sub-module; the timer is a single inline counter.

Test Plan:
- Reset then bytes 8'hA5, 8'h3C spaced 26040 cycles -> cmd=16'hA53C, cmd_rdy=1 one clk after second rx_rdy; clr_rx_rdy pulsed once per byte; timeout_err never.
- Byte 8'h12, then silence for 104160 cycles -> timeout_err pulses exactly once at cycle 104160 after acceptance; state IDLE. Then 8'h34, 8'h56 -> cmd=16'h3456.
- Low byte's rx_rdy arrives on the cycle timer==TIMEOUT_CYCLES-1 -> frame completes (cmd={hi,lo}), no timeout_err; one cycle later -> timeout_err, and that byte becomes the new high byte.
- cmd_rdy=1 (cmd=16'hA53C), host never clears, next byte 8'h01 -> cmd_rdy drops the next clk while cmd still reads 16'hA53C. After 8'h02, cmd=16'h0102 and cmd_rdy=1.
- clr_cmd_rdy held high on the completion cycle -> cmd_rdy=1 after the edge. clr_cmd_rdy one cycle later -> cmd_rdy=0.
- rst_n asserted mid-frame after high byte 8'hFF -> outputs at reset values immediately; following 8'h00, 8'h07 -> cmd=16'h0007, no timeout_err.
